// File: rtl/adder_pkg.sv
// Shared constants and helpers for the segmented pipelined adder.
// Holds the SUB encoding, the stage-count function and the configuration check.
package adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int num_segs(input int data_width, input int seg_width);
    return data_width / seg_width;
  endfunction

  // The width must split into whole segments.
  function automatic bit seg_cfg_ok(input int data_width, input int seg_width);
    return (seg_width > 0) && (data_width >= seg_width) && (data_width % seg_width == 0);
  endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result bus of the pipelined adder.
// The producer drives operands and result-ready; the adder drives the rest.
interface pipelined_adder_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  ci;
  logic                  sub;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] s;
  logic                  co;
  logic                  ovf;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output a, b, ci, sub, in_valid, out_ready,
    input  in_ready, s, co, ovf, out_valid
  );

  modport slave (
    input  a, b, ci, sub, in_valid, out_ready,
    output in_ready, s, co, ovf, out_valid
  );
endinterface

// File: rtl/adder_seg.sv
// Combinational SEG_WIDTH-bit ripple adder built from one_bit_adder cells.
module adder_seg #(
  parameter int SEG_WIDTH = 2
) (
  input  logic [SEG_WIDTH-1:0] a,
  input  logic [SEG_WIDTH-1:0] b,
  input  logic                 ci,
  output logic [SEG_WIDTH-1:0] s,
  output logic                 co
);
  logic [SEG_WIDTH:0] carry;

  assign carry[0] = ci;

  for (genvar gi = 0; gi < SEG_WIDTH; gi++) begin : g_bit
    one_bit_adder u_bit (
      .a  (a[gi]),
      .b  (b[gi]),
      .ci (carry[gi]),
      .s  (s[gi]),
      .co (carry[gi+1])
    );
  end

  assign co = carry[SEG_WIDTH];
endmodule

// File: rtl/one_bit_adder.sv
// Single-bit full adder cell used to build each segment.
module one_bit_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/pipelined_adder.sv
// Segmented add/subtract pipeline: one SEG_WIDTH slice per stage, carry registered
// between stages, valid/ready flow control with a whole-pipe stall.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SEG_WIDTH  = 2
) (
  input logic              clk,
  input logic              rst,
  pipelined_adder_if.slave bus
);
  localparam int NUM_SEGS = num_segs(DATA_WIDTH, SEG_WIDTH);
  localparam int MSB      = DATA_WIDTH - 1;
  localparam int LAST     = NUM_SEGS - 1;

  if (!seg_cfg_ok(DATA_WIDTH, SEG_WIDTH)) begin : g_cfg_check
    $error("pipelined_adder: DATA_WIDTH must be a multiple of SEG_WIDTH");
  end

  logic                advance;
  logic [DATA_WIDTH-1:0] bx_in;
  logic                cin_in;
  logic [DATA_WIDTH-1:0] s_reg;
  logic                co_reg;
  logic                ovf_reg;
  logic                out_valid_reg;

  assign advance      = !out_valid_reg || bus.out_ready;
  assign bus.in_ready = advance && !rst;
  assign bx_in        = (bus.sub == OP_SUB) ? ~bus.b : bus.b;
  assign cin_in       = bus.ci ^ bus.sub;

  // Stage gi carries only the operand bits not yet consumed (gi*SEG_WIDTH and up)
  // and the result bits already finished below them.
  for (genvar gi = 0; gi < NUM_SEGS; gi++) begin : g_stage
    localparam int LO = gi * SEG_WIDTH;

    logic                   valid_reg;
    logic                   carry_reg;
    logic [MSB:LO]          a_reg;
    logic [MSB:LO]          bx_reg;
    logic [SEG_WIDTH-1:0]   seg_sum;
    logic                   seg_co;
    logic [LO+SEG_WIDTH-1:0] done_next;

    adder_seg #(.SEG_WIDTH(SEG_WIDTH)) u_seg (
      .a  (a_reg[LO +: SEG_WIDTH]),
      .b  (bx_reg[LO +: SEG_WIDTH]),
      .ci (carry_reg),
      .s  (seg_sum),
      .co (seg_co)
    );

    if (gi == 0) begin : g_first
      assign done_next = seg_sum;

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg <= 1'b0;
          carry_reg <= 1'b0;
          a_reg     <= '0;
          bx_reg    <= '0;
        end else if (advance) begin
          valid_reg <= bus.in_valid && bus.in_ready;
          carry_reg <= cin_in;
          a_reg     <= bus.a;
          bx_reg    <= bx_in;
        end
      end
    end else begin : g_next
      logic [LO-1:0] done_reg;

      assign done_next = {seg_sum, done_reg};

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg <= 1'b0;
          carry_reg <= 1'b0;
          a_reg     <= '0;
          bx_reg    <= '0;
          done_reg  <= '0;
        end else if (advance) begin
          valid_reg <= g_stage[gi-1].valid_reg;
          carry_reg <= g_stage[gi-1].seg_co;
          a_reg     <= g_stage[gi-1].a_reg[MSB:LO];
          bx_reg    <= g_stage[gi-1].bx_reg[MSB:LO];
          done_reg  <= g_stage[gi-1].done_next;
        end
      end
    end
  end

  logic                  last_valid;
  logic [DATA_WIDTH-1:0] last_sum;
  logic                  last_co;
  logic                  last_a_msb;
  logic                  last_bx_msb;

  assign last_valid  = g_stage[LAST].valid_reg;
  assign last_sum    = g_stage[LAST].done_next;
  assign last_co     = g_stage[LAST].seg_co;
  assign last_a_msb  = g_stage[LAST].a_reg[MSB];
  assign last_bx_msb = g_stage[LAST].bx_reg[MSB];

  // Result registers only load on a real op, so bubbles never disturb S/CO/OVF.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      s_reg         <= '0;
      co_reg        <= 1'b0;
      ovf_reg       <= 1'b0;
    end else if (advance) begin
      out_valid_reg <= last_valid;
      if (last_valid) begin
        s_reg   <= last_sum;
        co_reg  <= last_co;
        ovf_reg <= (last_a_msb == last_bx_msb) && (last_sum[MSB] != last_a_msb);
      end
    end
  end

  assign bus.s         = s_reg;
  assign bus.co        = co_reg;
  assign bus.ovf       = ovf_reg;
  assign bus.out_valid = out_valid_reg;
endmodule
